// File: rtl/fp16_mac_top.sv
// FP16 multiply-accumulate: input regs -> product reg -> accumulator reg.
// Subnormals are read as zero and tiny results flush to zero; rounding is round-to-nearest-even.
module fp16_mac_top #(
  parameter int bw = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic [bw:1]   A,
  input  logic [bw:1]   B,
  output logic [bw:1]   out
);

  generate
    if (bw != 16) begin : g_bad_width
      $error("fp16_mac_top supports only bw = 16");
    end
  endgenerate

  function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic               s;
    logic [4:0]         ex, ey;
    logic [9:0]         fx, fy;
    logic               nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
    logic [21:0]        prod;
    logic [9:0]         frac;
    logic               g, st, up;
    logic signed [7:0]  e, e_f;
    logic [17:0]        er;
    logic [15:0]        r;
    s      = x[15] ^ y[15];
    ex     = x[14:10];
    ey     = y[14:10];
    fx     = x[9:0];
    fy     = y[9:0];
    nan_x  = (&ex) & (|fx);
    nan_y  = (&ey) & (|fy);
    inf_x  = (&ex) & ~(|fx);
    inf_y  = (&ey) & ~(|fy);
    zero_x = ~(|ex);
    zero_y = ~(|ey);
    if (nan_x | nan_y | ((inf_x | inf_y) & (zero_x | zero_y))) begin
      r = 16'h7E00;
    end else if (inf_x | inf_y) begin
      r = {s, 15'h7C00};
    end else if (zero_x | zero_y) begin
      r = {s, 15'h0000};
    end else begin
      prod = 22'({1'b1, fx}) * 22'({1'b1, fy});
      e    = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 8'sd15;
      if (prod[21]) begin
        frac = prod[20:11];
        g    = prod[10];
        st   = |prod[9:0];
        e    = e + 8'sd1;
      end else begin
        frac = prod[19:10];
        g    = prod[9];
        st   = |prod[8:0];
      end
      up  = g & (st | frac[0]);
      // A carry out of the fraction lands in the exponent field, which is the renormalization.
      er  = {e, frac} + {17'b0, up};
      e_f = $signed(er[17:10]);
      if (e_f > 8'sd30) begin
        r = {s, 15'h7C00};
      end else if (e_f < 8'sd1) begin
        r = {s, 15'h0000};
      end else begin
        r = {s, er[14:10], er[9:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic               sx, sy, sb, ss;
    logic [4:0]         ex, ey, eb, es, diff;
    logic [9:0]         fx, fy, fb, fs;
    logic               nan_x, nan_y, inf_x, inf_y, zero_x, zero_y, found;
    logic [3:0]         sh, lz;
    logic [13:0]        big_ext, small_ext, small_al, dif;
    logic [27:0]        wide;
    logic [14:0]        sum;
    logic [12:0]        norm;
    logic               up;
    logic signed [7:0]  e, e_f;
    logic [17:0]        er;
    logic [15:0]        r;
    sx     = x[15];
    sy     = y[15];
    ex     = x[14:10];
    ey     = y[14:10];
    fx     = x[9:0];
    fy     = y[9:0];
    nan_x  = (&ex) & (|fx);
    nan_y  = (&ey) & (|fy);
    inf_x  = (&ex) & ~(|fx);
    inf_y  = (&ey) & ~(|fy);
    zero_x = ~(|ex);
    zero_y = ~(|ey);
    if (nan_x | nan_y | (inf_x & inf_y & (sx != sy))) begin
      r = 16'h7E00;
    end else if (inf_x) begin
      r = {sx, 15'h7C00};
    end else if (inf_y) begin
      r = {sy, 15'h7C00};
    end else if (zero_x & zero_y) begin
      r = {sx & sy, 15'h0000};
    end else if (zero_x) begin
      r = y;
    end else if (zero_y) begin
      r = x;
    end else begin
      if ({ex, fx} >= {ey, fy}) begin
        sb = sx; eb = ex; fb = fx;
        ss = sy; es = ey; fs = fy;
      end else begin
        sb = sy; eb = ey; fb = fy;
        ss = sx; es = ex; fs = fx;
      end
      diff      = eb - es;
      sh        = (diff > 5'd13) ? 4'd13 : diff[3:0];
      big_ext   = {1'b1, fb, 3'b000};
      small_ext = {1'b1, fs, 3'b000};
      // Bits shifted past the low end fold into the sticky position.
      wide      = {small_ext, 14'b0} >> sh;
      small_al  = {wide[27:15], wide[14] | (|wide[13:0])};
      e         = $signed({3'b000, eb});
      norm      = '0;
      if (sb == ss) begin
        sum = {1'b0, big_ext} + {1'b0, small_al};
        if (sum[14]) begin
          norm = {sum[13:2], sum[1] | sum[0]};
          e    = e + 8'sd1;
        end else begin
          norm = sum[12:0];
        end
      end else begin
        dif   = big_ext - small_al;
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
          if (!found) begin
            if (dif[i]) found = 1'b1;
            else        lz    = lz + 4'd1;
          end
        end
        norm = 13'(dif << lz);
        e    = e - $signed({4'b0000, lz});
      end
      up  = norm[2] & ((|norm[1:0]) | norm[3]);
      er  = {e, norm[12:3]} + {17'b0, up};
      e_f = $signed(er[17:10]);
      if ((sb != ss) && (dif == 14'd0)) begin
        r = 16'h0000;
      end else if (e_f > 8'sd30) begin
        r = {sb, 15'h7C00};
      end else if (e_f < 8'sd1) begin
        r = {sb, 15'h0000};
      end else begin
        r = {sb, er[14:10], er[9:0]};
      end
    end
    return r;
  endfunction

  logic [15:0] a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d;

  always_comb begin
    a_d   = A;
    b_d   = B;
    p_d   = fp16_mul(a_q, b_q);
    acc_d = fp16_add(acc_q, p_q);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      acc_q <= acc_d;
    end
  end

  assign out = acc_q;

endmodule

// File: tb/tb_fp16_mac_top.sv
// Self-checking bench for fp16_mac_top: directed scenarios plus random operands
// checked against a real-arithmetic FP16 reference model.
module tb_fp16_mac_top;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [16:1] A, B;
  logic [16:1] out_s;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] acc_m;
  logic [15:0] pend[$];

  fp16_mac_top #(.bw(16)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .A      (A),
    .B      (B),
    .out    (out_s)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  function automatic bit is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'h0);
  endfunction

  function automatic bit is_zero(input logic [15:0] h);
    return h[14:10] == 5'h00;
  endfunction

  function automatic real mag(input logic [15:0] h);
    if (is_zero(h)) return 0.0;
    return real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
  endfunction

  // Round a positive exact value to FP16 (nearest-even), with overflow and flush rules.
  function automatic logic [15:0] to_fp16(input logic s, input real m_in);
    real m, sc, fr;
    int  e, ip;
    logic [4:0] ef;
    logic [9:0] ff;
    m = m_in;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc = m * 1024.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    if (e > 15)  return {s, 15'h7C00};
    if (e < -14) return {s, 15'h0000};
    ef = 5'(e + 15);
    ff = 10'(ip - 1024);
    return {s, ef, ff};
  endfunction

  function automatic logic [15:0] model_mul(input logic [15:0] x, input logic [15:0] y);
    logic s;
    s = x[15] ^ y[15];
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if ((is_inf(x) || is_inf(y)) && (is_zero(x) || is_zero(y))) return 16'h7E00;
    if (is_inf(x) || is_inf(y)) return {s, 15'h7C00};
    if (is_zero(x) || is_zero(y)) return {s, 15'h0000};
    return to_fp16(s, mag(x) * mag(y));
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
    real v;
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if (is_inf(x) && is_inf(y) && (x[15] != y[15])) return 16'h7E00;
    if (is_inf(x)) return {x[15], 15'h7C00};
    if (is_inf(y)) return {y[15], 15'h7C00};
    if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'h0000};
    v = (x[15] ? -mag(x) : mag(x)) + (y[15] ? -mag(y) : mag(y));
    if (v == 0.0) return 16'h0000;
    if (v < 0.0) return to_fp16(1'b1, -v);
    return to_fp16(1'b0, v);
  endfunction

  // Products enter a queue when their operands are sampled; the accumulator
  // absorbs the one sampled two edges earlier. Reset leaves two zero products in flight.
  task automatic model_reset();
    acc_m = 16'h0000;
    pend.delete();
    pend.push_back(16'h0000);
    pend.push_back(16'h0000);
  endtask

  task automatic tick(input logic [15:0] a, input logic [15:0] b);
    A = a;
    B = b;
    @(posedge CLK);
    pend.push_back(model_mul(a, b));
    if (pend.size() > 2) acc_m = model_add(acc_m, pend.pop_front());
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    A = 16'h0000;
    B = 16'h0000;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    model_reset();
    RESETn = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4)  return 16'($urandom);
    if (r < 8)  return {1'($urandom), 5'h00, 10'($urandom)};
    return {1'($urandom), 5'($urandom_range(5, 22)), 10'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESETn = 1'b0;
    A = 16'hCACA;
    B = 16'hD035;
    #2;
    n_total++;
    if (out_s !== 16'h0000) $display("FAIL reset_initial: out=%h expected=%h", out_s, 16'h0000);
    else n_pass++;
    repeat (3) @(posedge CLK);
    #1;
    n_total++;
    if (out_s !== 16'h0000) $display("FAIL reset_held: out=%h expected=%h", out_s, 16'h0000);
    else n_pass++;
    A = 16'h3C00;
    B = 16'h4000;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (out_s !== 16'h0000) $display("FAIL reset_inputs_change: out=%h expected=%h", out_s, 16'h0000);
    else n_pass++;
    A = 16'hCACA;
    B = 16'hD035;
    model_reset();
  endtask

  task automatic test_accum_sequence();
    logic [15:0] tbl [7];
    tbl = '{16'h0000, 16'h0000, 16'h5F24, 16'h6324, 16'h655B, 16'h6724, 16'h6876};
    RESETn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(16'hCACA, 16'hD035);
      n_total++;
      if (out_s !== tbl[i]) $display("FAIL accum_seq edge %0d: out=%h expected=%h", i + 1, out_s, tbl[i]);
      else n_pass++;
      n_total++;
      if (out_s !== acc_m) $display("FAIL accum_model edge %0d: out=%h expected=%h", i + 1, out_s, acc_m);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick(16'hCACA, 16'hD035);
      n_total++;
      if (out_s !== acc_m) $display("FAIL overflow_model cycle %0d: out=%h expected=%h", i, out_s, acc_m);
      else n_pass++;
      if (out_s === 16'h7C00) reached = 1'b1;
    end
    n_total++;
    if (out_s !== 16'h7C00 || !reached) $display("FAIL overflow_hold: out=%h expected=%h", out_s, 16'h7C00);
    else n_pass++;
  endtask

  task automatic test_cancel_nan();
    logic [15:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick((i % 2 == 0) ? 16'h3C00 : 16'hBC00, 16'h3C00);
      n_total++;
      if (out_s !== acc_m) $display("FAIL cancel_model edge %0d: out=%h expected=%h", i, out_s, acc_m);
      else n_pass++;
      if (i >= 2) begin
        want = (i % 2 == 0) ? 16'h3C00 : 16'h0000;
        n_total++;
        if (out_s !== want) $display("FAIL cancel_toggle edge %0d: out=%h expected=%h", i, out_s, want);
        else n_pass++;
      end
    end
    tick(16'h7C00, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      tick(16'h0000, 16'h0000);
      n_total++;
      if (out_s !== acc_m) $display("FAIL nan_model edge %0d: out=%h expected=%h", k, out_s, acc_m);
      else n_pass++;
      if (k >= 2) begin
        n_total++;
        if (out_s !== 16'h7E00) $display("FAIL nan_sticky edge %0d: out=%h expected=%h", k, out_s, 16'h7E00);
        else n_pass++;
      end
    end
  endtask

  task automatic test_latency();
    logic [15:0] want;
    do_reset();
    tick(16'h0000, 16'h0000);
    tick(16'h0000, 16'h0000);
    tick(16'h4000, 16'h4200);
    n_total++;
    if (out_s !== 16'h0000) $display("FAIL latency_edge1: out=%h expected=%h", out_s, 16'h0000);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      tick(16'h0000, 16'h0000);
      want = (k >= 2) ? 16'h4600 : 16'h0000;
      n_total++;
      if (out_s !== want) $display("FAIL latency_edge%0d: out=%h expected=%h", k + 1, out_s, want);
      else n_pass++;
      n_total++;
      if (out_s !== acc_m) $display("FAIL latency_model edge %0d: out=%h expected=%h", k + 1, out_s, acc_m);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        a = rand_op();
        b = rand_op();
        tick(a, b);
        n_total++;
        if (out_s !== acc_m)
          $display("FAIL random seg %0d cyc %0d a=%h b=%h: out=%h expected=%h", seg, i, a, b, out_s, acc_m);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] tbl [3];
    tbl = '{16'h0000, 16'h0000, 16'h5F24};
    do_reset();
    repeat (6) tick(16'hCACA, 16'hD035);
    n_total++;
    if (out_s !== acc_m) $display("FAIL async_prerun: out=%h expected=%h", out_s, acc_m);
    else n_pass++;
    #3;
    RESETn = 1'b0;
    #1;
    n_total++;
    if (out_s !== 16'h0000) $display("FAIL async_reset_immediate: out=%h expected=%h", out_s, 16'h0000);
    else n_pass++;
    model_reset();
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(16'hCACA, 16'hD035);
      n_total++;
      if (out_s !== tbl[i]) $display("FAIL async_restart edge %0d: out=%h expected=%h", i + 1, out_s, tbl[i]);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_accum_sequence();
    test_overflow();
    test_cancel_nan();
    test_latency();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
